sub_word_engine: RTL and testbench

Sequential, parametrised AES byte-substitution engine: accepts a word of WORD_BYTES bytes over a valid/ready handshake and applies the AES S-box to every byte, LANES bytes per clock. When built with the inverse option, each word can instead use the inverse S-box. It replaces the combinational subWord in key expansion and is shared with the SubBytes round stage, trading area for latency.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/aes_sbox.sv | 34 +++
 rtl/sub_word_engine.sv | 124 ++++++++++++
 tb/tb_sub_word_engine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES constants: forward and inverse S-box tables and
//                the byte-substitution engine FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Engine FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Forward AES S-box, indexed by input byte
  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Inverse AES S-box, indexed by substituted byte
  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES byte substitution. The inverse table is
//                only built when SUB_WORD_ENGINE_INV_EN is defined; otherwise
//                the inv input is ignored and the forward table is used.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       inv,
  output logic [7:0] byte_out
);

`ifdef SUB_WORD_ENGINE_INV_EN
  // Table lookup, direction chosen per word by the engine's mode flag
  always_comb begin
    byte_out = inv ? SBOX_INV[byte_in] : SBOX_FWD[byte_in];
  end
`else
  // Forward-only build keeps the port for a uniform interface
  logic w_unused_inv;
  assign w_unused_inv = inv;

  // Forward table lookup
  always_comb begin
    byte_out = SBOX_FWD[byte_in];
  end
`endif

endmodule
`default_nettype wire

// File: rtl/sub_word_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sub_word_engine
//  Description : Sequential AES SubWord/SubBytes engine. Takes a word of
//                WORD_BYTES bytes over valid/ready and substitutes LANES
//                bytes per clock in place, then presents the word until the
//                consumer accepts it. Optional macro SUB_WORD_ENGINE_INV_EN
//                adds a per-word inverse S-box mode selected by in_inv.
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_word_engine
  import aes_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int LANES      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:8*WORD_BYTES-1] in_data,
  input  logic                    in_inv,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:8*WORD_BYTES-1] out_data
);

  localparam int BEATS = (LANES > 0) ? (WORD_BYTES / LANES) : 1;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((WORD_BYTES < 1) || (LANES < 1) ||
      ((LANES > 0) && ((WORD_BYTES % LANES) != 0))) begin : g_param_check
    $error("sub_word_engine: LANES must be >=1 and divide WORD_BYTES (>=1)");
  end

  state_t                  r_state;
  state_t                  w_state_next;
  logic [0:8*WORD_BYTES-1] r_work;
  logic [0:8*WORD_BYTES-1] w_work_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_inv;
  logic                    w_inv_sel;
  logic [7:0]              w_lane_in  [LANES];
  logic [7:0]              w_lane_out [LANES];

`ifdef SUB_WORD_ENGINE_INV_EN
  assign w_inv_sel = in_inv;
`else
  // Mode flag tied to forward; in_inv is kept on the port but unused
  logic w_unused_inv;
  assign w_unused_inv = in_inv;
  assign w_inv_sel    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: accept in IDLE, count beats in BUSY, hold in DONE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = BUSY;
      BUSY:    if (r_cnt == LAST_BEAT) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Select the current beat's bytes and merge the substituted bytes back
  always_comb begin
    w_work_next = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_lane_in[l] = r_work[8*(int'(r_cnt)*LANES + l) +: 8];
      w_work_next[8*(int'(r_cnt)*LANES + l) +: 8] = w_lane_out[l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox u_sbox (
      .byte_in  (w_lane_in[l]),
      .inv      (r_inv),
      .byte_out (w_lane_out[l])
    );
  end

  // Working register, beat counter and mode flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_inv  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work <= in_data;
            r_inv  <= w_inv_sel;
            r_cnt  <= '0;
          end
        end
        BUSY: begin
          r_work <= w_work_next;
          // Counter saturates on the last beat rather than wrapping
          if (r_cnt != LAST_BEAT) r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  // Result is exposed only while it is valid, so idle/reset output is zero
  assign out_data  = out_valid ? r_work : '0;

endmodule
`default_nettype wire

// File: tb/tb_sub_word_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sub_word_engine
//  Description : Self-checking bench for sub_word_engine. Four instances
//                (4x1, 4x4, 4x2, 16x4 bytes x lanes) share clock and reset.
//                Expectations follow SUB_WORD_ENGINE_INV_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_word_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: 4 bytes, 1 lane
  logic a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
  logic [0:31] a_in_data, a_out_data;
  // Instance B: 4 bytes, 4 lanes
  logic b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
  logic [0:31] b_in_data, b_out_data;
  // Instance C: 4 bytes, 2 lanes
  logic c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready;
  logic [0:31] c_in_data, c_out_data;
  // Instance D: 16 bytes, 4 lanes
  logic d_in_valid, d_in_ready, d_in_inv, d_out_valid, d_out_ready;
  logic [0:127] d_in_data, d_out_data;

  sub_word_engine #(.WORD_BYTES(4), .LANES(1)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_inv(a_in_inv), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data));
  sub_word_engine #(.WORD_BYTES(4), .LANES(4)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_inv(b_in_inv), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data));
  sub_word_engine #(.WORD_BYTES(4), .LANES(2)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_inv(c_in_inv), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data));
  sub_word_engine #(.WORD_BYTES(16), .LANES(4)) u_d (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .in_inv(d_in_inv), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_data(d_out_data));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // ---------------- reference S-box from GF(2^8) arithmetic ----------------
  logic [7:0] fwd_m [256];
  logic [7:0] inv_m [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] y = 8'h00;
    if (x != 8'h00)
      for (int c = 1; c < 256; c++)
        if (gmul(x, 8'(c)) == 8'h01) y = 8'(c);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] word_ref(input logic [127:0] din, input int nbytes, input logic inv);
    logic [127:0] r = '0;
    logic [7:0]   b;
    for (int k = 0; k < nbytes; k++) begin
      b = din[8*(nbytes-1-k) +: 8];
`ifdef SUB_WORD_ENGINE_INV_EN
      r[8*(nbytes-1-k) +: 8] = inv ? inv_m[b] : fwd_m[b];
`else
      r[8*(nbytes-1-k) +: 8] = fwd_m[b];
`endif
    end
    return r;
  endfunction

  // ---------------- per-instance access helpers ----------------
  task automatic drive(input int sel, input logic [127:0] din, input logic inv, input logic v);
    case (sel)
      0: begin a_in_data = din[31:0]; a_in_inv = inv; a_in_valid = v; end
      1: begin b_in_data = din[31:0]; b_in_inv = inv; b_in_valid = v; end
      2: begin c_in_data = din[31:0]; c_in_inv = inv; c_in_valid = v; end
      default: begin d_in_data = din; d_in_inv = inv; d_in_valid = v; end
    endcase
  endtask

  function automatic logic get_ir(input int sel);
    case (sel)
      0: return a_in_ready;
      1: return b_in_ready;
      2: return c_in_ready;
      default: return d_in_ready;
    endcase
  endfunction

  function automatic logic get_ov(input int sel);
    case (sel)
      0: return a_out_valid;
      1: return b_out_valid;
      2: return c_out_valid;
      default: return d_out_valid;
    endcase
  endfunction

  function automatic logic [127:0] get_od(input int sel);
    case (sel)
      0: return {96'b0, a_out_data};
      1: return {96'b0, b_out_data};
      2: return {96'b0, c_out_data};
      default: return d_out_data;
    endcase
  endfunction

  // One word through an instance. lat = edges from accept to out_valid seen;
  // waits = extra cycles spent waiting for in_ready. Returns at the sample
  // point where out_valid is high; out_ready governs the handshake after.
  task automatic xfer(input int sel, input logic [127:0] din, input logic inv,
                      output logic [127:0] dout, output int lat, output int waits);
    waits = 0;
    @(negedge clk);
    while (!get_ir(sel) && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    drive(sel, din, inv, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(sel, din, inv, 1'b0);
    lat = 0;
    while (!get_ov(sel) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    dout = get_od(sel);
  endtask

  typedef struct {
    logic [31:0] din;
    logic        inv;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [127:0] dout;
    logic [127:0] held;
    logic [127:0] dwords [3];
    logic         dinv   [3];
    int           lat;
    int           waits;
    logic         ov_ok, ir_ok, od_ok;

    vecs[0] = '{32'h00000000, 1'b0, 32'h63636363};
    vecs[1] = '{32'h01234567, 1'b0, 32'h7c266e85};
    vecs[2] = '{32'h10203040, 1'b0, 32'hcab70409};
    vecs[3] = '{32'hffffffff, 1'b0, 32'h16161616};
`ifdef SUB_WORD_ENGINE_INV_EN
    vecs[4] = '{32'h63636363, 1'b1, 32'h00000000};
    vecs[5] = '{32'h53535353, 1'b0, 32'hedededed};
    vecs[6] = '{32'h00000000, 1'b1, 32'h52525252};
`else
    vecs[4] = '{32'h63636363, 1'b1, 32'hfbfbfbfb};
    vecs[5] = '{32'h53535353, 1'b0, 32'hedededed};
    vecs[6] = '{32'h00000000, 1'b1, 32'h63636363};
`endif

    for (int i = 0; i < 256; i++) fwd_m[i] = sbox_ref(8'(i));
    for (int i = 0; i < 256; i++) inv_m[fwd_m[i]] = 8'(i);

    reset = 1'b1;
    for (int s = 0; s < 4; s++) drive(s, '0, 1'b0, 1'b0);
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1; d_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset in_ready", 128'(a_in_ready), 128'(1));
    check("reset out_valid", 128'(a_out_valid), 128'(0));
    check("reset out_data", 128'(a_out_data), 128'(0));
    reset = 1'b0;

    // Table-driven words through the 1-lane instance
    for (int i = 0; i < 7; i++) begin
      xfer(0, 128'(vecs[i].din), vecs[i].inv, dout, lat, waits);
      check($sformatf("vec%0d data", i), dout, 128'(vecs[i].exp));
      check($sformatf("vec%0d latency", i), 128'(lat), 128'(4));
    end

    // Wider lane counts: same word, shorter latency
    xfer(1, 128'h01234567, 1'b0, dout, lat, waits);
    check("4lane data", dout, 128'h7c266e85);
    check("4lane latency", 128'(lat), 128'(1));
    xfer(2, 128'h01234567, 1'b0, dout, lat, waits);
    check("2lane data", dout, 128'h7c266e85);
    check("2lane latency", 128'(lat), 128'(2));

    // Stall in DONE for 10 cycles while a new word is offered
    a_out_ready = 1'b0;
    xfer(0, 128'h10203040, 1'b0, held, lat, waits);
    ov_ok = 1'b1; ir_ok = 1'b1; od_ok = 1'b1;
    drive(0, 128'hffffffff, 1'b0, 1'b1);
    repeat (10) begin
      @(negedge clk);
      if (a_out_valid !== 1'b1) ov_ok = 1'b0;
      if (a_in_ready !== 1'b0) ir_ok = 1'b0;
      if ({96'b0, a_out_data} !== held) od_ok = 1'b0;
    end
    check("stall out_valid held", 128'(ov_ok), 128'(1));
    check("stall in_ready low", 128'(ir_ok), 128'(1));
    check("stall out_data stable", 128'(od_ok), 128'(1));
    check("stall out_data value", held, 128'h cab70409);
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post-handshake in_ready", 128'(a_in_ready), 128'(1));
    check("post-handshake out_valid", 128'(a_out_valid), 128'(0));
    @(posedge clk);
    @(negedge clk);
    drive(0, '0, 1'b0, 1'b0);
    lat = 0;
    while (!a_out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("second word data", 128'(a_out_data), 128'h16161616);
    check("second word latency", 128'(lat), 128'(4));

    // Reset during beat 2 of 4
    @(negedge clk);
    drive(0, 128'h01234567, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 128'h01234567, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset in_ready", 128'(a_in_ready), 128'(1));
    check("midreset out_valid", 128'(a_out_valid), 128'(0));
    check("midreset out_data", 128'(a_out_data), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after reset in_ready", 128'(a_in_ready), 128'(1));
    check("after reset out_valid", 128'(a_out_valid), 128'(0));
    xfer(0, 128'h00000000, 1'b0, dout, lat, waits);
    check("after reset word", dout, 128'h63636363);
    check("after reset latency", 128'(lat), 128'(4));

    // 16-byte, 4-lane back-to-back words against the GF reference
    dwords[0] = 128'h00112233445566778899aabbccddeeff; dinv[0] = 1'b0;
    dwords[1] = 128'h000102030405060708090a0b0c0d0e0f; dinv[1] = 1'b1;
    dwords[2] = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f; dinv[2] = 1'b0;
    for (int w = 0; w < 3; w++) begin
      xfer(3, dwords[w], dinv[w], dout, lat, waits);
      check($sformatf("d word%0d data", w), dout, word_ref(dwords[w], 16, dinv[w]));
      check($sformatf("d word%0d latency", w), 128'(lat), 128'(4));
      if (w > 0) check($sformatf("d word%0d accept wait", w), 128'(waits), 128'(0));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
